// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller.
// Feeds one full-adder cell one operand bit pair per clock, LSB first. The
// running carry lives in a flip-flop and sum bits shift into the result
// register from the top. Subtraction uses a - b = a + ~b + 1, with the +1
// supplied as the initial carry.

module onebit_adder (
    input  logic in_1,
    input  logic in_2,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    assign sum   = in_1 ^ in_2 ^ c_in;
    assign c_out = (in_1 & in_2) | (c_in & (in_1 ^ in_2));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_c_out;
    logic             r_overflow;
    logic             w_sum;
    logic             w_cout;

    onebit_adder u_fa (
        .in_1  (r_a_sh[0]),
        .in_2  (r_b_sh[0]),
        .c_in  (r_carry),
        .sum   (w_sum),
        .c_out (w_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: start is honoured only in IDLE; DONE lasts one cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST_BIT) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_RUN;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then one adder step per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh     <= {WIDTH{1'b0}};
            r_b_sh     <= {WIDTH{1'b0}};
            r_carry    <= 1'b0;
            r_cnt      <= {CW{1'b0}};
            r_result   <= {WIDTH{1'b0}};
            r_c_out    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= sub ? ~b : b;
                        r_carry <= sub;
                        r_cnt   <= {CW{1'b0}};
                    end
                end
                S_RUN: begin
                    r_result <= {w_sum, r_result[WIDTH-1:1]};
                    r_carry  <= w_cout;
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_cnt    <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    if (r_cnt == LAST_BIT) begin
                        // r_carry here is the carry into the MSB
                        r_c_out    <= w_cout;
                        r_overflow <= r_carry ^ w_cout;
                    end
                end
                S_DONE: begin
                    r_cnt <= {CW{1'b0}};
                end
                default: begin
                    r_cnt <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign result   = r_result;
    assign c_out    = r_c_out;
    assign overflow = r_overflow;

endmodule
